conv_sched: RTL and testbench
=============================

// Module: conv_sched
// PURPOSE
//  Sequencer for the BNN convolution stage. Waits for the pixel/weight register bank to report a complete load.
//  Then walks every valid 3x3 window position for every filter and issues each one to the XNOR-popcount datapath over a
//  valid/ready handshake, limiting how many windows are in flight at once. In-order result bits coming back are written
//  to the feature map; a single done pulse is raised when the map is complete.
// PARAMETERS
//  IMG_DIM  28  input image side length (pixels)
//  K        3   kernel side length
//  N_FILT   8   number of binary filters
//  MAX_OUT  2   max windows issued but not yet answered (datapath pipeline depth)
//  (derived) OUT_DIM = IMG_DIM-K+1 = 26; CW = $clog2(IMG_DIM) = 5; FW = $clog2(N_FILT) = 3
// PORTS
//  clk        in   1    single clock, all logic on posedge
//  reset      in   1    synchronous, active-high reset
//  start      in   1    request one inference pass; sampled only in IDLE
//  load_done  in   1    pixel+weight bank full (level); sampled only in WAIT_LOAD
//  busy       out  1    high in every state except IDLE
//  done       out  1    one-cycle pulse after last feature-map write
//  err        out  1    sticky: res_valid arrived with zero windows in flight; cleared only by reset
//  win_valid  out  1    window descriptor valid
//  win_ready  in   1    datapath accepts descriptor
//  win_filt   out  FW   filter index of issued window
//  win_row    out  CW   top-left row of window (0..OUT_DIM-1)
//  win_col    out  CW   top-left col of window (0..OUT_DIM-1)
//  res_valid  in   1    datapath result strobe (one per accepted window, in issue order)
//  res_bit    in   1    binarised (sign) result
//  fm_we      out  1    feature-map write enable
//  fm_filt    out  FW   write filter index
//  fm_row     out  CW   write row
//  fm_col     out  CW   write col
//  fm_bit     out  1    write data
// BEHAVIOUR
//  Reset: state=IDLE; busy, done, err, win_valid, fm_we = 0; all indices and fm_bit = 0; in-flight count = 0.
//  States: IDLE -(start)-> WAIT_LOAD -(load_done)-> ISSUE -(last window accepted)-> DRAIN
//    -(last result written)-> FINISH -> IDLE.
//  In FINISH, done=1 for exactly that one cycle.
//  Order: filter outermost, then row, then col. Col wraps at OUT_DIM-1 -> 0 and increments row.
//    Row wraps at OUT_DIM-1 -> 0 and increments filter. Last window = (N_FILT-1, OUT_DIM-1, OUT_DIM-1).
//  Total windows = N_FILT*OUT_DIM^2 = 5408.
//  Issue: win_valid = (state==ISSUE) && (in-flight < MAX_OUT). Descriptor is registered.
//    win_filt/row/col are held stable while win_valid && !win_ready.
//    Accept = win_valid && win_ready; the issue counter advances on the next edge.
//  In-flight count: +1 on accept, -1 on res_valid (when nonzero), unchanged on simultaneous accept+res_valid.
//    Never exceeds MAX_OUT.
//  Writeback: on res_valid with in-flight>0, fm_we=1 for the next cycle (1-cycle registered latency).
//    fm_bit=res_bit; fm_filt/row/col come from a second window counter that advances per result.
//  DRAIN -> FINISH once the write counter has wrapped past the last window and in-flight == 0.
//  res_valid with in-flight==0, in any state: result dropped, no fm_we, err<=1.
//  start while busy is ignored. load_done is not re-checked after leaving WAIT_LOAD.
//  A deassert of load_done mid-pass has no effect.
//  win_ready outside ISSUE is ignored.
//  Reset asserted mid-pass: next cycle matches the reset values; any results returned afterwards are counted as
//    spurious (err).
// STRUCTURE
//  bnn_pkg: IMG_DIM, K, N_FILT, OUT_DIM, CW, FW constants; sched_state_t enum
//    {IDLE, WAIT_LOAD, ISSUE, DRAIN, FINISH}.
//  Sub-module win_counter: nested filt/row/col counter with inc, clr, and a last flag (high at the final index).
//    Instantiated twice: issue side and writeback side.
//  Top level holds the FSM, the in-flight counter, err, and the output registers.
// TESTING
//  1 reset; start=1 with load_done=1, win_ready=1, datapath model returning res 2 cycles after accept.
//    -> first window (0,0,0); 27th window is (0,1,0); 5408 accepts, 5408 fm_we, fm order identical to issue order.
//    -> done pulses exactly once, then busy=0.
//  2 start with load_done=0 for 50 cycles -> busy=1, win_valid=0 throughout; load_done=1 -> win_valid next cycle
//    at (0,0,0).
//  3 win_ready=1, res_valid never asserted -> exactly 2 accepts (0,0,0), (0,0,1), then win_valid=0 indefinitely.
//    One res_valid -> exactly one more accept.
//  4 win_ready=0 for 5 cycles while win_valid=1 -> win_filt/row/col unchanged. Raise win_ready -> single accept.
//  5 reset during window #100 -> next cycle busy=0, win_valid=0, counters 0. New start restarts at (0,0,0).
//  6 res_valid=1 in IDLE -> fm_we stays 0, err=1 and remains 1 through a full pass until reset.

Source files
------------

// File: rtl/bnn_pkg.sv
// Shared sizing constants and scheduler state encoding for the BNN convolution stage.
package bnn_pkg;

  localparam int IMG_DIM = 28;
  localparam int K       = 3;
  localparam int N_FILT  = 8;
  localparam int MAX_OUT = 2;

  localparam int OUT_DIM = IMG_DIM - K + 1;
  localparam int CW      = $clog2(IMG_DIM);
  localparam int FW      = $clog2(N_FILT);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    WAIT_LOAD = 3'd1,
    ISSUE     = 3'd2,
    DRAIN     = 3'd3,
    FINISH    = 3'd4
  } sched_state_t;

endpackage

// File: rtl/win_counter.sv
// Nested filter/row/col window counter; col is innermost and filter outermost.
module win_counter
  import bnn_pkg::*;
(
  input  logic          clk,
  input  logic          reset,
  input  logic          clr_i,
  input  logic          inc_i,
  output logic [FW-1:0] filt_o,
  output logic [CW-1:0] row_o,
  output logic [CW-1:0] col_o,
  output logic          last_o
);

  localparam logic [CW-1:0] DIM_MAX  = CW'(OUT_DIM - 1);
  localparam logic [FW-1:0] FILT_MAX = FW'(N_FILT - 1);

  logic [FW-1:0] filt_q, filt_d;
  logic [CW-1:0] row_q, row_d;
  logic [CW-1:0] col_q, col_d;

  always_comb begin
    filt_d = filt_q;
    row_d  = row_q;
    col_d  = col_q;
    if (clr_i) begin
      filt_d = '0;
      row_d  = '0;
      col_d  = '0;
    end else if (inc_i) begin
      if (col_q == DIM_MAX) begin
        col_d = '0;
        if (row_q == DIM_MAX) begin
          row_d  = '0;
          filt_d = (filt_q == FILT_MAX) ? '0 : filt_q + FW'(1);
        end else begin
          row_d = row_q + CW'(1);
        end
      end else begin
        col_d = col_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      filt_q <= '0;
      row_q  <= '0;
      col_q  <= '0;
    end else begin
      filt_q <= filt_d;
      row_q  <= row_d;
      col_q  <= col_d;
    end
  end

  assign filt_o = filt_q;
  assign row_o  = row_q;
  assign col_o  = col_q;
  assign last_o = (filt_q == FILT_MAX) && (row_q == DIM_MAX) && (col_q == DIM_MAX);

endmodule

// File: rtl/conv_sched.sv
// Convolution window sequencer: issues every (filter,row,col) window to the datapath with
// bounded outstanding requests and writes the in-order result bits back to the feature map.
module conv_sched
  import bnn_pkg::*;
(
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic          load_done,
  output logic          busy,
  output logic          done,
  output logic          err,
  output logic          win_valid,
  input  logic          win_ready,
  output logic [FW-1:0] win_filt,
  output logic [CW-1:0] win_row,
  output logic [CW-1:0] win_col,
  input  logic          res_valid,
  input  logic          res_bit,
  output logic          fm_we,
  output logic [FW-1:0] fm_filt,
  output logic [CW-1:0] fm_row,
  output logic [CW-1:0] fm_col,
  output logic          fm_bit
);

  localparam int             IW        = $clog2(MAX_OUT + 1);
  localparam logic [IW-1:0]  MAX_OUT_C = IW'(MAX_OUT);

  sched_state_t  state_q, state_d;
  logic [IW-1:0] inflight_q, inflight_d;
  logic          err_q;
  logic          wr_done_q;

  logic          fm_we_q;
  logic          fm_bit_q;
  logic [FW-1:0] fm_filt_q;
  logic [CW-1:0] fm_row_q;
  logic [CW-1:0] fm_col_q;

  logic          launch;
  logic          accept;
  logic          res_ok;
  logic          iss_last;
  logic          wr_last;
  logic [FW-1:0] wr_filt;
  logic [CW-1:0] wr_row;
  logic [CW-1:0] wr_col;

  assign launch    = (state_q == IDLE) && start;
  assign win_valid = (state_q == ISSUE) && (inflight_q < MAX_OUT_C);
  assign accept    = win_valid && win_ready;
  // A result only counts when something is outstanding; anything else is spurious.
  assign res_ok    = res_valid && (inflight_q != '0);

  win_counter u_iss_cnt (
    .clk    (clk),
    .reset  (reset),
    .clr_i  (launch),
    .inc_i  (accept),
    .filt_o (win_filt),
    .row_o  (win_row),
    .col_o  (win_col),
    .last_o (iss_last)
  );

  win_counter u_wr_cnt (
    .clk    (clk),
    .reset  (reset),
    .clr_i  (launch),
    .inc_i  (res_ok),
    .filt_o (wr_filt),
    .row_o  (wr_row),
    .col_o  (wr_col),
    .last_o (wr_last)
  );

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:      if (start)              state_d = WAIT_LOAD;
      WAIT_LOAD: if (load_done)          state_d = ISSUE;
      ISSUE:     if (accept && iss_last) state_d = DRAIN;
      DRAIN:     if (wr_done_q && (inflight_q == '0)) state_d = FINISH;
      FINISH:                            state_d = IDLE;
      default:                           state_d = IDLE;
    endcase
  end

  always_comb begin
    inflight_d = inflight_q;
    if (accept && !res_ok) begin
      inflight_d = inflight_q + IW'(1);
    end else if (!accept && res_ok) begin
      inflight_d = inflight_q - IW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      inflight_q <= '0;
      err_q      <= 1'b0;
      wr_done_q  <= 1'b0;
      fm_we_q    <= 1'b0;
      fm_bit_q   <= 1'b0;
      fm_filt_q  <= '0;
      fm_row_q   <= '0;
      fm_col_q   <= '0;
    end else begin
      state_q    <= state_d;
      inflight_q <= inflight_d;
      fm_we_q    <= res_ok;
      if (res_valid && !res_ok) begin
        err_q <= 1'b1;
      end
      if (launch) begin
        wr_done_q <= 1'b0;
      end else if (res_ok && wr_last) begin
        wr_done_q <= 1'b1;
      end
      // Writeback stage: capture the result with the write-side window it belongs to.
      if (res_ok) begin
        fm_bit_q  <= res_bit;
        fm_filt_q <= wr_filt;
        fm_row_q  <= wr_row;
        fm_col_q  <= wr_col;
      end
    end
  end

  assign busy    = (state_q != IDLE);
  assign done    = (state_q == FINISH);
  assign err     = err_q;
  assign fm_we   = fm_we_q;
  assign fm_bit  = fm_bit_q;
  assign fm_filt = fm_filt_q;
  assign fm_row  = fm_row_q;
  assign fm_col  = fm_col_q;

endmodule

// File: tb/tb_conv_sched.sv
// Directed bench for conv_sched: full pass, load wait, backpressure, in-flight limit, reset, spurious results.
module tb_conv_sched;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic       load_done;
  logic       busy;
  logic       done;
  logic       err;
  logic       win_valid;
  logic       win_ready;
  logic [2:0] win_filt;
  logic [4:0] win_row;
  logic [4:0] win_col;
  logic       res_valid;
  logic       res_bit;
  logic       fm_we;
  logic [2:0] fm_filt;
  logic [4:0] fm_row;
  logic [4:0] fm_col;
  logic       fm_bit;

  int n_vec = 0;
  int n_err = 0;

  conv_sched dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .load_done (load_done),
    .busy      (busy),
    .done      (done),
    .err       (err),
    .win_valid (win_valid),
    .win_ready (win_ready),
    .win_filt  (win_filt),
    .win_row   (win_row),
    .win_col   (win_col),
    .res_valid (res_valid),
    .res_bit   (res_bit),
    .fm_we     (fm_we),
    .fm_filt   (fm_filt),
    .fm_row    (fm_row),
    .fm_col    (fm_col),
    .fm_bit    (fm_bit)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset     = 1'b1;
    start     = 1'b0;
    load_done = 1'b0;
    win_ready = 1'b0;
    res_valid = 1'b0;
    res_bit   = 1'b0;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    n_vec++;
    if ({busy, done, err, win_valid, fm_we, fm_bit} !== 6'b0) begin
      n_err++;
      $display("FAIL reset_ctrl: busy/done/err/wv/we/bit=%b, want 000000",
               {busy, done, err, win_valid, fm_we, fm_bit});
    end
    n_vec++;
    if ({win_filt, win_row, win_col, fm_filt, fm_row, fm_col} !== 26'd0) begin
      n_err++;
      $display("FAIL reset_idx: win=(%0d,%0d,%0d) fm=(%0d,%0d,%0d), want all 0",
               win_filt, win_row, win_col, fm_filt, fm_row, fm_col);
    end
  endtask

  // Full pass with a datapath that answers two cycles after each accept.
  task automatic test_full_pass(input logic exp_err);
    int n_acc = 0, n_wr = 0, n_done = 0, bad_iss = 0, bad_wr = 0, err_bad = 0;
    int first_bad = -1;
    logic p1 = 1'b0, p2 = 1'b0, acc, b, finished = 1'b0;
    logic bitq[$];
    logic fmq[$];
    logic [2:0] ef;
    logic [4:0] er, ec;
    start = 1'b1; load_done = 1'b1; win_ready = 1'b1; res_valid = 1'b0;
    tick();
    start = 1'b0;
    for (int cyc = 0; cyc < 20000 && !finished; cyc++) begin
      tick();
      if (err !== exp_err) err_bad++;
      if (fm_we === 1'b1) begin
        ef = 3'(n_wr / 676); er = 5'((n_wr % 676) / 26); ec = 5'(n_wr % 26);
        b = (fmq.size() > 0) ? fmq.pop_front() : 1'bx;
        if ({fm_filt, fm_row, fm_col, fm_bit} !== {ef, er, ec, b}) begin
          bad_wr++;
          if (first_bad < 0) first_bad = n_wr;
        end
        n_wr++;
      end
      if (done === 1'b1) begin
        n_done++;
        finished = 1'b1;
      end
      acc = (win_valid === 1'b1) && (win_ready === 1'b1);
      if (acc) begin
        if (n_acc == 0) begin
          n_vec++;
          if ({win_filt, win_row, win_col} !== 13'd0) begin
            n_err++;
            $display("FAIL first_window: got (%0d,%0d,%0d), want (0,0,0)", win_filt, win_row, win_col);
          end
        end
        if (n_acc == 26) begin
          n_vec++;
          if ({win_filt, win_row, win_col} !== {3'd0, 5'd1, 5'd0}) begin
            n_err++;
            $display("FAIL window_27: got (%0d,%0d,%0d), want (0,1,0)", win_filt, win_row, win_col);
          end
        end
        ef = 3'(n_acc / 676); er = 5'((n_acc % 676) / 26); ec = 5'(n_acc % 26);
        if ({win_filt, win_row, win_col} !== {ef, er, ec}) begin
          bad_iss++;
          if (first_bad < 0) first_bad = n_acc;
        end
        bitq.push_back(1'(n_acc % 2) ^ 1'((n_acc / 8) % 2));
        n_acc++;
      end
      res_valid = p2;
      res_bit   = 1'b0;
      if (p2) begin
        res_bit = (bitq.size() > 0) ? bitq.pop_front() : 1'b0;
        fmq.push_back(res_bit);
      end
      p2 = p1;
      p1 = acc;
    end
    res_valid = 1'b0; win_ready = 1'b0; load_done = 1'b0;
    tick();
    n_vec++;
    if (!finished) begin
      n_err++;
      $display("FAIL pass_timeout: done not seen, accepts=%0d writes=%0d", n_acc, n_wr);
    end
    n_vec++;
    if (n_acc != 5408) begin
      n_err++;
      $display("FAIL accept_count: got %0d, want 5408", n_acc);
    end
    n_vec++;
    if (n_wr != 5408) begin
      n_err++;
      $display("FAIL write_count: got %0d, want 5408", n_wr);
    end
    n_vec++;
    if (bad_iss != 0 || bad_wr != 0) begin
      n_err++;
      $display("FAIL order: issue errs=%0d write errs=%0d first at %0d, want 0", bad_iss, bad_wr, first_bad);
    end
    n_vec++;
    if (n_done != 1 || done !== 1'b0 || busy !== 1'b0) begin
      n_err++;
      $display("FAIL done_pulse: pulses=%0d done=%b busy=%b after, want 1,0,0", n_done, done, busy);
    end
    n_vec++;
    if (err_bad != 0 || err !== exp_err) begin
      n_err++;
      $display("FAIL err_during_pass: %0d cycles off, err=%b, want %b", err_bad, err, exp_err);
    end
  endtask

  task automatic test_wait_load();
    int bad = 0;
    do_reset();
    start = 1'b1; load_done = 1'b0; win_ready = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 50; i++) begin
      if (busy !== 1'b1 || win_valid !== 1'b0) bad++;
      tick();
    end
    n_vec++;
    if (bad != 0) begin
      n_err++;
      $display("FAIL wait_load_hold: %0d bad cycles, want busy=1 win_valid=0", bad);
    end
    load_done = 1'b1;
    win_ready = 1'b0;
    tick();
    n_vec++;
    if ({win_valid, win_filt, win_row, win_col} !== {1'b1, 13'd0}) begin
      n_err++;
      $display("FAIL load_release: wv=%b (%0d,%0d,%0d), want 1 (0,0,0)", win_valid, win_filt, win_row, win_col);
    end
  endtask

  task automatic test_inflight_limit();
    int n = 0;
    logic [12:0] d0 = '1, d1 = '1, d2 = '1;
    do_reset();
    start = 1'b1; load_done = 1'b1; win_ready = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (win_valid === 1'b1) begin
        if (n == 0) d0 = {win_filt, win_row, win_col};
        if (n == 1) d1 = {win_filt, win_row, win_col};
        n++;
      end
      tick();
    end
    n_vec++;
    if (n != 2 || d0 !== 13'd0 || d1 !== 13'd1 || win_valid !== 1'b0) begin
      n_err++;
      $display("FAIL inflight_cap: accepts=%0d d0=%h d1=%h wv=%b, want 2 0000 0001 0", n, d0, d1, win_valid);
    end
    res_valid = 1'b1; res_bit = 1'b1;
    tick();
    res_valid = 1'b0; res_bit = 1'b0;
    n_vec++;
    if ({fm_we, fm_filt, fm_row, fm_col, fm_bit, err} !== {1'b1, 13'd0, 1'b1, 1'b0}) begin
      n_err++;
      $display("FAIL first_write: we=%b (%0d,%0d,%0d) bit=%b err=%b, want 1 (0,0,0) 1 0",
               fm_we, fm_filt, fm_row, fm_col, fm_bit, err);
    end
    n = 0;
    for (int i = 0; i < 10; i++) begin
      if (win_valid === 1'b1) begin
        d2 = {win_filt, win_row, win_col};
        n++;
      end
      tick();
    end
    n_vec++;
    if (n != 1 || d2 !== 13'd2) begin
      n_err++;
      $display("FAIL one_more: accepts=%0d desc=%h, want 1 0002", n, d2);
    end
  endtask

  task automatic test_backpressure();
    int bad = 0;
    do_reset();
    start = 1'b1; load_done = 1'b1; win_ready = 1'b0;
    tick();
    start = 1'b0;
    tick();
    win_ready = 1'b1;
    tick();
    win_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      if ({win_valid, win_filt, win_row, win_col} !== {1'b1, 13'd1}) bad++;
      tick();
    end
    n_vec++;
    if (bad != 0) begin
      n_err++;
      $display("FAIL hold_desc: %0d cycles changed, now wv=%b (%0d,%0d,%0d), want 1 (0,0,1)",
               bad, win_valid, win_filt, win_row, win_col);
    end
    win_ready = 1'b1;
    tick();
    win_ready = 1'b0;
    tick();
    n_vec++;
    if ({win_filt, win_row, win_col} !== 13'd2 || win_valid !== 1'b0) begin
      n_err++;
      $display("FAIL single_accept: (%0d,%0d,%0d) wv=%b, want (0,0,2) 0", win_filt, win_row, win_col, win_valid);
    end
  endtask

  task automatic test_reset_mid_pass();
    int n_acc = 0;
    logic p1 = 1'b0, p2 = 1'b0, acc, hit = 1'b0;
    do_reset();
    start = 1'b1; load_done = 1'b1; win_ready = 1'b1;
    tick();
    start = 1'b0;
    for (int cyc = 0; cyc < 1000 && !hit; cyc++) begin
      if (n_acc == 100 && win_valid === 1'b1) begin
        hit = 1'b1;
      end else begin
        acc = (win_valid === 1'b1);
        if (acc) n_acc++;
        res_valid = p2;
        p2 = p1;
        p1 = acc;
        tick();
      end
    end
    n_vec++;
    if (!hit || {win_filt, win_row, win_col} !== {3'd0, 5'd3, 5'd22}) begin
      n_err++;
      $display("FAIL window_100: reached=%b (%0d,%0d,%0d), want 1 (0,3,22)", hit, win_filt, win_row, win_col);
    end
    reset = 1'b1; res_valid = 1'b0;
    tick();
    reset = 1'b0; win_ready = 1'b0;
    n_vec++;
    if ({busy, win_valid, done, fm_we, win_filt, win_row, win_col} !== 17'd0) begin
      n_err++;
      $display("FAIL reset_mid: busy=%b wv=%b done=%b we=%b (%0d,%0d,%0d), want all 0",
               busy, win_valid, done, fm_we, win_filt, win_row, win_col);
    end
    res_valid = 1'b1;
    tick();
    res_valid = 1'b0;
    n_vec++;
    if (err !== 1'b1 || fm_we !== 1'b0) begin
      n_err++;
      $display("FAIL late_result: err=%b we=%b, want 1 0", err, fm_we);
    end
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    n_vec++;
    if ({win_valid, win_filt, win_row, win_col} !== {1'b1, 13'd0}) begin
      n_err++;
      $display("FAIL restart: wv=%b (%0d,%0d,%0d), want 1 (0,0,0)", win_valid, win_filt, win_row, win_col);
    end
  endtask

  task automatic test_spurious_err();
    do_reset();
    res_valid = 1'b1; res_bit = 1'b1;
    tick();
    res_valid = 1'b0; res_bit = 1'b0;
    n_vec++;
    if (fm_we !== 1'b0 || err !== 1'b1 || busy !== 1'b0) begin
      n_err++;
      $display("FAIL idle_result: we=%b err=%b busy=%b, want 0 1 0", fm_we, err, busy);
    end
    tick();
    n_vec++;
    if (fm_we !== 1'b0 || err !== 1'b1) begin
      n_err++;
      $display("FAIL err_sticky: we=%b err=%b, want 0 1", fm_we, err);
    end
    test_full_pass(1'b1);
    do_reset();
    n_vec++;
    if (err !== 1'b0) begin
      n_err++;
      $display("FAIL err_clear: err=%b, want 0", err);
    end
  endtask

  initial begin
    test_reset();
    test_full_pass(1'b0);
    test_wait_load();
    test_inflight_limit();
    test_backpressure();
    test_reset_mid_pass();
    test_spurious_err();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
